fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined LEGv8 CPU. It sits directly upstream of the decode/control stage. It holds the PC, presents the fetch address to instruction memory, and registers the fetched word and its PC into IF/ID. Branches resolved in decode redirect the PC here: the block computes the branch target from the IF/ID instruction and squashes the wrong-path fetch. A hazard-unit stall freezes both the PC and IF/ID.

## Interface
- RESET_PC, default 64'h0, PC value loaded on reset.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- imem_addr  out  64  fetch address; equals the PC register (combinational from the register).
- imem_data  in  32  instruction word at imem_addr; combinational read, valid in the same cycle.
- stall  in  1  from the hazard unit; holds PC and IF/ID.
- br_taken  in  1  from control; the branch in IF/ID is taken this cycle.
- uncond_br  in  1  from control; 1 selects imm26 (B), 0 selects imm19 (CBZ/B.LT).
- id_instr  out  32  IF/ID instruction register.
- id_pc  out  64  IF/ID PC register (address of id_instr).
- id_valid  out  1  IF/ID holds a real instruction; 0 means a bubble.
- br_target  out  64  combinational branch target for the IF/ID instruction.
- flush_count  out  16  count of squashed fetches, for performance monitoring.

## Operation
- Target computation:
  - imm26 = id_instr[25:0]; imm19 = id_instr[23:5].
  - Sign-extend the selected field to 64 bits, shift left by 2, and add to id_pc.
  - Addition is modulo 2^64; overflow wraps silently.
  - br_target is computed every cycle. It is meaningful only when br_taken=1.
- Next-state priority, evaluated at each rising edge:
  1. reset_n=0: PC←RESET_PC; id_instr←32'h0; id_pc←64'h0; id_valid←0; flush_count←0.
  2. stall=1: PC, id_instr, id_pc, id_valid and flush_count all hold. br_taken is ignored; decode re-presents the branch once the stall drops.
  3. br_taken=1: PC←br_target. IF/ID is loaded with a bubble (id_instr←32'h0, id_pc←64'h0, id_valid←0). flush_count increments, saturating at 16'hFFFF.
  4. Otherwise: PC←PC+4 (wraps at 2^64); id_instr←imem_data; id_pc←PC; id_valid←1.
- Bubble encoding 32'h0 decodes to the control default (no register write, no memory write, no branch).
- br_taken and uncond_br are consumed only when id_valid=1. When id_valid=0 they are treated as 0, so a bubble never redirects the PC.
- PC low two bits are never altered by this block. RESET_PC must be word-aligned.

## Timing
- Reset values:
  - imem_addr = RESET_PC
  - id_instr = 0
  - id_pc = 0
  - id_valid = 0
  - br_target = 0 (derived from the reset IF/ID contents)
  - flush_count = 0
- Fetch-to-decode latency is 1 cycle. The word at address A, fetched in cycle n, appears on id_instr in cycle n+1, with id_pc = A.
- Taken-branch penalty is 1 bubble:
  - Branch in ID in cycle n.
  - Target fetched in cycle n+1.
  - Target appears in ID in cycle n+2.
  - id_valid=0 in cycle n+1.
- Stall for k cycles: outputs are frozen for exactly k cycles. No instruction is lost or duplicated.
- Reset mid-operation overrides stall and br_taken in the same edge. The first post-reset fetch is RESET_PC, and it reaches ID one cycle after reset_n rises.

## Test plan
- Reset, then free run with imem[i] = i+1: imem_addr steps 0, 4, 8, 12. id_instr is 1, 2, 3 with id_pc 0, 4, 8. id_valid=0 only in the first cycle after reset.
- B with imm26=3, id_pc=0x8, br_taken=1, uncond_br=1: br_target=0x14 and next imem_addr=0x14. The following cycle shows id_valid=0 and id_instr=0. flush_count=1.
- CBZ with imm19=0x7FFFE (−2), id_pc=0x20, br_taken=1, uncond_br=0: br_target=0x18 and next PC=0x18.
- stall=1 for 3 cycles at PC=0x10 with id_pc=0xC: all outputs hold for 3 cycles. Then id_pc=0x10 and PC=0x14.
- stall=1 and br_taken=1 together: the PC holds and flush_count is unchanged. When stall drops with br_taken still 1, the redirect occurs.
- reset_n=0 asserted while br_taken=1 and stall=1: the next edge gives PC=RESET_PC, id_valid=0 and flush_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC and drives it to instruction memory. Registers the fetched word
// and its PC into IF/ID. A taken branch in decode redirects the PC to a target
// computed here from the IF/ID instruction, and the wrong-path fetch is
// replaced by a bubble. A hazard-unit stall freezes the PC and IF/ID.
//
// Ports:
//   clk, reset_n   clock; synchronous active-low reset
//   imem_addr      fetch address (the PC register)
//   imem_data      instruction word at imem_addr, same cycle
//   stall          hold the PC and IF/ID
//   br_taken       the branch in IF/ID is taken
//   uncond_br      1: imm26 offset (B), 0: imm19 offset (CBZ/B.cond)
//   id_instr/id_pc IF/ID instruction and its address
//   id_valid       IF/ID holds a real instruction (0 = bubble)
//   br_target      branch target for the IF/ID instruction
//   flush_count    saturating count of squashed fetches
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        uncond_br,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        id_valid,
  output logic [63:0] br_target,
  output logic [15:0] flush_count
);

  logic [63:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [63:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic        br_eff;
  logic        uncond_eff;
  logic [63:0] br_offset;

  // Control inputs are meaningless for a bubble, so gate them with id_valid.
  always_comb begin
    br_eff     = br_taken & id_valid_q;
    uncond_eff = uncond_br & id_valid_q;
    if (uncond_eff) begin
      br_offset = {{36{id_instr_q[25]}}, id_instr_q[25:0], 2'b00};
    end else begin
      br_offset = {{43{id_instr_q[23]}}, id_instr_q[23:5], 2'b00};
    end
  end

  assign br_target = id_pc_q + br_offset;

  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;
    flush_count_d = flush_count_q;
    if (!stall) begin
      if (br_eff) begin
        pc_d       = br_target;
        id_instr_d = '0;
        id_pc_d    = '0;
        id_valid_d = 1'b0;
        if (flush_count_q != '1) begin
          flush_count_d = flush_count_q + 16'd1;
        end
      end else begin
        pc_d       = pc_q + 64'd4;
        id_instr_d = imem_data;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_valid_q    <= 1'b0;
      flush_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_valid_q    <= id_valid_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_valid    = id_valid_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven bench for fetch_stage. Each vector holds the
// inputs for one clock, the br_target expected while those inputs are applied,
// and the outputs expected after the edge. Post-edge expectations go through a
// scoreboard queue. A trailing hand-written sequence covers target wrap-around.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        br_taken;
  logic        uncond_br;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_valid;
  logic [63:0] br_target;
  logic [15:0] flush_count;

  logic [31:0] mem [64];

  int unsigned n_checks;
  int unsigned n_pass;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic        unc;
    logic        chk_tgt;
    logic [63:0] tgt;
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
    logic [15:0] flush;
  } vec_t;

  vec_t vecs [21];
  vec_t exp_q [$];

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .br_taken    (br_taken),
    .uncond_br   (uncond_br),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .br_target   (br_target),
    .flush_count (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @* imem_data = mem[imem_addr[7:2]];

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic u, input logic ct, input logic [63:0] t,
                              input logic [63:0] a, input logic [31:0] i,
                              input logic [63:0] p, input logic v,
                              input logic [15:0] f);
    vec_t x;
    x = '{rst_n: r, stall: s, br: b, unc: u, chk_tgt: ct, tgt: t,
          addr: a, instr: i, pc: p, valid: v, flush: f};
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset_n   = v.rst_n;
    stall     = v.stall;
    br_taken  = v.br;
    uncond_br = v.unc;
    #1;
    if (v.chk_tgt) chk("br_target", br_target, v.tgt);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("imem_addr", imem_addr, e.addr);
      chk("id_instr", {32'h0, id_instr}, {32'h0, e.instr});
      chk("id_pc", id_pc, e.pc);
      chk("id_valid", {63'h0, id_valid}, {63'h0, e.valid});
      chk("flush_count", {48'h0, flush_count}, {48'h0, e.flush});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    uncond_br = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
    mem[8] = 32'hB4FF_FFC0; // CBZ, imm19 = 0x7FFFE (-2)

    //            rst st br un ct tgt            addr           instr          pc             v  flush
    vecs[0]  = mk(0, 0, 0, 0, 0, 64'h0,          64'h0,  32'h0,         64'h0,  0, 16'd0);
    vecs[1]  = mk(1, 0, 0, 0, 1, 64'h0,          64'h4,  32'h1,         64'h0,  1, 16'd0);
    vecs[2]  = mk(1, 0, 0, 0, 1, 64'h0,          64'h8,  32'h2,         64'h4,  1, 16'd0);
    vecs[3]  = mk(1, 0, 0, 0, 1, 64'h4,          64'hC,  32'h3,         64'h8,  1, 16'd0);
    // B imm26=3 at id_pc 0x8
    vecs[4]  = mk(1, 0, 1, 1, 1, 64'h14,         64'h14, 32'h0,         64'h0,  0, 16'd1);
    // br_taken held over the bubble must not redirect
    vecs[5]  = mk(1, 0, 1, 1, 1, 64'h0,          64'h18, 32'h6,         64'h14, 1, 16'd1);
    vecs[6]  = mk(1, 0, 0, 0, 1, 64'h14,         64'h1C, 32'h7,         64'h18, 1, 16'd1);
    vecs[7]  = mk(1, 0, 0, 0, 1, 64'h18,         64'h20, 32'h8,         64'h1C, 1, 16'd1);
    vecs[8]  = mk(1, 0, 0, 0, 1, 64'h1C,         64'h24, 32'hB4FF_FFC0, 64'h20, 1, 16'd1);
    // CBZ imm19=-2 at id_pc 0x20
    vecs[9]  = mk(1, 0, 1, 0, 1, 64'h18,         64'h18, 32'h0,         64'h0,  0, 16'd2);
    vecs[10] = mk(1, 0, 0, 0, 1, 64'h0,          64'h1C, 32'h7,         64'h18, 1, 16'd2);
    // stall for 3 cycles, then resume without loss or duplication
    vecs[11] = mk(1, 1, 0, 0, 1, 64'h18,         64'h1C, 32'h7,         64'h18, 1, 16'd2);
    vecs[12] = mk(1, 1, 0, 0, 1, 64'h18,         64'h1C, 32'h7,         64'h18, 1, 16'd2);
    vecs[13] = mk(1, 1, 0, 0, 1, 64'h18,         64'h1C, 32'h7,         64'h18, 1, 16'd2);
    vecs[14] = mk(1, 0, 0, 0, 1, 64'h18,         64'h20, 32'h8,         64'h1C, 1, 16'd2);
    // stall with a taken B (imm26=8): hold, then redirect once stall drops
    vecs[15] = mk(1, 1, 1, 1, 1, 64'h3C,         64'h20, 32'h8,         64'h1C, 1, 16'd2);
    vecs[16] = mk(1, 1, 1, 1, 1, 64'h3C,         64'h20, 32'h8,         64'h1C, 1, 16'd2);
    vecs[17] = mk(1, 0, 1, 1, 1, 64'h3C,         64'h3C, 32'h0,         64'h0,  0, 16'd3);
    vecs[18] = mk(1, 0, 0, 0, 1, 64'h0,          64'h40, 32'h10,        64'h3C, 1, 16'd3);
    // reset overrides stall and br_taken
    vecs[19] = mk(0, 1, 1, 1, 1, 64'h7C,         64'h0,  32'h0,         64'h0,  0, 16'd0);
    vecs[20] = mk(1, 0, 0, 0, 1, 64'h0,          64'h4,  32'h1,         64'h0,  1, 16'd0);

    for (int i = 0; i < 21; i++) apply(vecs[i]);

    // Backward B (imm26=-2) at id_pc 0x4 wraps the target below zero,
    // then PC+4 wraps back to zero.
    mem[1] = 32'h17FF_FFFE;
    apply(mk(1, 0, 0, 0, 1, 64'h0, 64'h8, 32'h17FF_FFFE, 64'h4, 1, 16'd0));
    apply(mk(1, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
             32'h0, 64'h0, 0, 16'd1));
    apply(mk(1, 0, 0, 0, 1, 64'h0, 64'h0, 32'h40, 64'hFFFF_FFFF_FFFF_FFFC, 1, 16'd1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
